// File: rtl/count_bcd_converter.sv
// rtl/count_bcd_converter.sv - iterative shift-and-add-3 binary to packed BCD converter
// Optional macro BCD_AUTOSTART_EN: launch a conversion whenever bin differs from the last converted value.
module count_bcd_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  ready,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic bit digits_fit();
        longint p;
        p = 1;
        for (int i = 0; i < DIGITS; i++) p = p * 10;
        return p > ((longint'(1) << WIDTH) - 1);
    endfunction

    localparam bit FITS = digits_fit();

    generate
        if (!FITS) begin : g_digits_too_few
            $error("count_bcd_converter: DIGITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t            state;
    logic [WIDTH-1:0]  shift_reg;
    logic [SW-1:0]     scratch;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     adj;
    logic [SW-1:0]     next_scratch;
    logic [WIDTH-1:0]  next_shift;
    logic              launch;

`ifdef BCD_AUTOSTART_EN
    logic [WIDTH-1:0]  last_val;
    logic              unused_start;
    assign unused_start = start;
    assign launch = (bin != last_val);
`else
    assign launch = start;
`endif

    // One 4-bit add-3 per digit, then the whole {scratch, shift} pair moves left.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            else
                adj[4*i +: 4] = scratch[4*i +: 4];
        end
        next_scratch = {adj[SW-2:0], shift_reg[WIDTH-1]};
        next_shift   = {shift_reg[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            cnt       <= '0;
            bcd       <= '0;
            valid     <= 1'b0;
            ready     <= 1'b1;
            busy      <= 1'b0;
`ifdef BCD_AUTOSTART_EN
            last_val  <= '0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        shift_reg <= bin;
                        scratch   <= '0;
                        cnt       <= '0;
                        state     <= SHIFT;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
`ifdef BCD_AUTOSTART_EN
                        last_val  <= bin;
`endif
                    end
                end
                SHIFT: begin
                    scratch   <= next_scratch;
                    shift_reg <= next_shift;
                    cnt       <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        bcd   <= next_scratch;
                        valid <= 1'b1;
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_bcd_converter.sv
// tb/tb_count_bcd_converter.sv - self-checking bench for count_bcd_converter
module tb_count_bcd_converter;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  bin = '0;
    logic              ready, valid, busy;
    logic [11:0]       bcd;

    int errors = 0;
    int checks = 0;

    count_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .ready(ready), .valid(valid), .bcd(bcd), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        int x;
        x = v;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-count model: a conversion occupies WIDTH edges, then publishes the decimal value.
    int          m_rem = 0;
    int          m_val = 0;
    logic        m_valid = 1'b0;
    logic [11:0] m_bcd = '0;
    logic [WIDTH-1:0] m_last = '0;
    logic        m_on = 1'b0;
    logic        m_launch;

`ifdef BCD_AUTOSTART_EN
    assign m_launch = (bin != m_last);
`else
    assign m_launch = start;
`endif

    always @(posedge clk) begin
        if (rst) begin
            m_rem   <= 0;
            m_valid <= 1'b0;
            m_bcd   <= '0;
            m_last  <= '0;
            m_on    <= 1'b1;
        end else begin
            m_valid <= 1'b0;
            if (m_rem == 0) begin
                if (m_launch) begin
                    m_rem  <= WIDTH;
                    m_val  <= int'(bin);
                    m_last <= bin;
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_valid <= 1'b1;
                    m_bcd   <= to_bcd(m_val);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("valid", 32'(valid), 32'(m_valid));
            check("ready", 32'(ready), 32'(m_rem == 0));
            check("busy",  32'(busy),  32'(m_rem != 0));
            check("bcd",   32'(bcd),   32'(m_bcd));
        end
    end

    int valid_seen = 0;
    always @(posedge clk) if (valid) valid_seen <= valid_seen + 1;

    // Waits (from posedge+1) for valid; returns cycles counted from the acceptance edge.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("timeout_valid", 32'd0, 32'd1);
    endtask

    // Called at posedge+1; returns at posedge+1 of the valid cycle.
    task automatic do_conv(input int v, output int lat);
        bin = WIDTH'(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(lat);
    endtask

    int lat;
    int vcount;

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_bcd",   32'(bcd),   32'h000);

`ifdef BCD_AUTOSTART_EN
        vcount = valid_seen;
        repeat (20) @(posedge clk);
        #1;
        check("auto_idle_no_valid", 32'(valid_seen - vcount), 32'd0);
        bin = 8'd1;
        wait_valid(lat);
        check("auto_bcd_1", 32'(bcd), 32'h001);
        vcount = valid_seen;
        repeat (15) @(posedge clk);
        #1;
        check("auto_hold_no_valid", 32'(valid_seen - vcount), 32'd0);
        bin = 8'd2;
        wait_valid(lat);
        check("auto_bcd_2", 32'(bcd), 32'h002);
        repeat (3) @(posedge clk);
        #1;
`else
        do_conv(255, lat);
        check("lat_255", 32'(lat), 32'd8);
        check("bcd_255", 32'(bcd), 32'h255);

        do_conv(0, lat);
        check("bcd_0", 32'(bcd), 32'h000);
        @(posedge clk); #1;
        check("valid_single_cycle", 32'(valid), 32'd0);

        do_conv(0, lat);
        do_conv(100, lat);
        check("b2b_lat", 32'(lat), 32'd8);
        check("bcd_100", 32'(bcd), 32'h100);

        @(posedge clk); #1;
        vcount = valid_seen;
        bin = 8'd9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bin = 8'd200;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("ignored_bcd", 32'(bcd), 32'h009);
        check("ignored_one_valid", 32'(valid_seen - vcount), 32'd1);

        vcount = valid_seen;
        bin = 8'd137;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_bcd",   32'(bcd),   32'h000);
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_valid", 32'(valid_seen - vcount), 32'd0);
        do_conv(137, lat);
        check("bcd_137", 32'(bcd), 32'h137);

        for (int v = 0; v < 256; v++) begin
            do_conv(v, lat);
            check("sweep_bcd", 32'(bcd), 32'(to_bcd(v)));
            for (int d = 0; d < 3; d++)
                if (bcd[4*d +: 4] > 4'd9) check("sweep_digit_le9", 32'(bcd[4*d +: 4]), 32'd9);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_bcd_converter.md
Name: count_bcd_converter

Overview:
Downstream stage of the 8-bit counter. Takes the counter's binary count value and converts it to packed BCD digits using an iterative shift-and-add-3 (double-dabble) method. Its output drives the decimal display path. It is a multi-cycle engine with a start/ready/valid handshake, so it uses one adder per digit rather than a combinational divider.

Parameters:
WIDTH, 8, width of binary input; matches counter WIDTH
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1, else elaboration error

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request conversion of bin; honoured only when ready=1
bin  input  WIDTH  binary value to convert (counter count output)
ready  output  1  high when idle and able to accept start
valid  output  1  one-cycle pulse: bcd updated with a new result
bcd  output  4*DIGITS  packed BCD; digit 0 in bits [3:0], least significant decimal digit
busy  output  1  high while a conversion is in progress (equals ~ready)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: ready=1, busy=0, valid=0, bcd=0. FSM goes to IDLE, internal shift and scratch registers are cleared.
- FSM states: IDLE, SHIFT.
- IDLE:
  - If start=1 at an edge, capture bin into the shift register.
  - Clear the BCD scratch register and set the bit counter to 0.
  - Go to SHIFT. ready drops in the next cycle.
- SHIFT: each cycle:
  - Every scratch digit >= 5 has 3 added to it.
  - Then {scratch, shift} is shifted left by 1.
  - The bit counter increments.
- Exit from SHIFT: on the edge that completes shift number WIDTH:
  - bcd <= final scratch.
  - valid <= 1 for exactly one cycle.
  - FSM goes to IDLE.
- Latency: start accepted at edge E0; valid is high in the cycle after edge E_WIDTH (WIDTH cycles after acceptance). Throughput is one result per WIDTH cycles.
- The cycle in which valid=1 is an IDLE cycle with ready=1, so a start in that cycle is accepted (back-to-back conversions).
- start while busy: ignored, not queued. bin changes while busy: no effect, because bin is captured at acceptance.
- bcd holds the last result until the next completion. It is never partially updated.
- Arithmetic: each digit add-3 is 4-bit, and no digit exceeds 9 after conversion. The bit counter is $clog2(WIDTH+1) bits wide.
- Reset mid-conversion: abort immediately, no valid pulse, all outputs return to reset values.
- valid and ready are registered outputs. No combinational path from input to output.

Optional Feature:
Macro BCD_AUTOSTART_EN.
- Defined:
  - Add an internal last-value register (reset 0).
  - In IDLE, a conversion launches automatically in any cycle where bin != last-value register. On that launch, the last-value register <= bin.
  - The start port is ignored.
  - The display therefore tracks the counter with no external control. A constant bin produces no further conversions or valid pulses.
- Not defined: conversions start only via the start handshake. The last-value register does not exist.

Test Plan:
- WIDTH=8, DIGITS=3. Reset, then bin=8'd255 with start pulse → valid high exactly 8 cycles after acceptance, bcd=12'h255, ready=0 during those cycles.
- bin=8'd0 start → bcd=12'h000, valid single-cycle. Then bin=8'd100 start in the valid cycle (back-to-back) → accepted, next result bcd=12'h100.
- Start at bin=8'd9; at cycle 3 of conversion, change bin to 8'd200 and pulse start → ignored, result bcd=12'h009, only one valid pulse.
- Start conversion of 8'd137; assert rst at cycle 4 → no valid pulse, bcd=0, ready=1 next cycle. A fresh start of 8'd137 then gives 12'h137.
- Sweep bin 0..255, each followed by a start → bcd matches a reference decimal conversion for every value, no digit >9.
- With BCD_AUTOSTART_EN defined:
  - Hold start=0, drive bin 0→1→1→2 → conversions fire only on the changes, valid pulses give bcd 12'h001 then 12'h002.
  - Holding bin=0 after reset produces no valid.
